// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared opcode, ALU function and control-word definitions for the execute/control slice.
package cpu_exec_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALU_OP_W = 3;

    // Primary opcodes (instruction[31:26])
    localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b000001;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b010000;
    localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
    localparam logic [OP_W-1:0] OP_OR   = 6'b010010;
    localparam logic [OP_W-1:0] OP_MOVE = 6'b100000;
    localparam logic [OP_W-1:0] OP_SW   = 6'b100110;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100111;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b110000;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    // ALU function codes
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_RSUB = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_ANDN = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_XNOR = 3'b111;

    // Raw decoded control word, before halt/reset gating
    typedef struct packed {
        logic                ext_sel;
        logic                pc_wre;
        logic                reg_out;
        logic                reg_wre;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_b;
        logic                alu_m2reg;
        logic                branch;
        logic                dmem_rw;
    } ctrl_t;

endpackage

// File: rtl/cpu_exec_ctrl_alu.sv
// 32-bit ALU with operand-B select and zero detect.
module cpu_alu
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b_reg,
    input  logic [WIDTH-1:0]    b_imm,
    input  logic                alu_src_b,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic [WIDTH-1:0]    result,
    output logic                zero
);

    logic [WIDTH-1:0] b;

    // Operand select and function evaluation; add/sub wrap naturally
    always_comb begin
        b      = alu_src_b ? b_imm : b_reg;
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_RSUB: result = b - a;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_ANDN: result = ~a & b;
            ALU_XOR:  result = a ^ b;
            ALU_XNOR: result = ~(a ^ b);
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execute/control slice: opcode decode, ALU, writeback mux and sticky halt flag.
module cpu_exec_ctrl
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic [WIDTH-1:0]    InputDataA,
    input  logic [WIDTH-1:0]    InputDataB,
    input  logic [WIDTH-1:0]    ImmediateDataB,
    input  logic [WIDTH-1:0]    MemDataOut,
    output logic                ExtSel,
    output logic                PCWre,
    output logic                InsMemRW,
    output logic                RegOut,
    output logic                RegWre,
    output logic [ALU_OP_W-1:0] ALUOp,
    output logic                ALUSrcB,
    output logic                ALUM2Reg,
    output logic                PCSrc,
    output logic                DataMemRW,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic [WIDTH-1:0]    WriteData,
    output logic                halted
);

    ctrl_t ctrl;
    logic  halted_q;
    logic  halted_d;
    logic  blocked;

    // Raw opcode decode; unknown opcodes fall through as NOP
    always_comb begin
        ctrl        = '0;
        ctrl.pc_wre = 1'b1;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_ADD: begin
                ctrl.reg_out = 1'b1;
                ctrl.reg_wre = 1'b1;
                ctrl.ext_sel = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_wre   = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
            end
            OP_SUB: begin
                ctrl.reg_out = 1'b1;
                ctrl.reg_wre = 1'b1;
                ctrl.alu_op  = ALU_SUB;
                ctrl.ext_sel = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_wre   = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = ALU_OR;
            end
            OP_AND: begin
                ctrl.reg_out = 1'b1;
                ctrl.reg_wre = 1'b1;
                ctrl.alu_op  = ALU_AND;
            end
            OP_OR: begin
                ctrl.reg_out = 1'b1;
                ctrl.reg_wre = 1'b1;
                ctrl.alu_op  = ALU_OR;
            end
            OP_MOVE: begin
                ctrl.reg_out = 1'b1;
                ctrl.reg_wre = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
                ctrl.dmem_rw   = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
                ctrl.alu_m2reg = 1'b1;
                ctrl.reg_wre   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op  = ALU_SUB;
                ctrl.ext_sel = 1'b1;
                ctrl.branch  = 1'b1;
            end
            OP_HALT: begin
                ctrl.pc_wre = 1'b0;
            end
            default: ;
        endcase
    end

    // ALU datapath; zero only feeds PCSrc so no combinational loop
    cpu_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a        (InputDataA),
        .b_reg    (InputDataB),
        .b_imm    (ImmediateDataB),
        .alu_src_b(ctrl.alu_src_b),
        .alu_op   (ctrl.alu_op),
        .result   (result),
        .zero     (zero)
    );

    // Gate side-effecting controls by halt state and reset; reset has final say
    always_comb begin
        blocked   = halted_q || (opcode == OP_HALT);
        ExtSel    = ctrl.ext_sel;
        InsMemRW  = 1'b0;
        RegOut    = ctrl.reg_out;
        ALUOp     = ctrl.alu_op;
        ALUSrcB   = ctrl.alu_src_b;
        ALUM2Reg  = ctrl.alu_m2reg;
        PCWre     = ctrl.pc_wre  && !blocked;
        RegWre    = ctrl.reg_wre && !blocked;
        DataMemRW = ctrl.dmem_rw && !blocked;
        PCSrc     = ctrl.branch && zero && !blocked;
        if (!reset) begin
            PCWre     = 1'b1;
            RegWre    = 1'b0;
            DataMemRW = 1'b0;
            PCSrc     = 1'b0;
        end
    end

    // Writeback select: memory data for loads, ALU result otherwise
    always_comb begin
        WriteData = ctrl.alu_m2reg ? MemDataOut : result;
    end

    // Next halt state: sticky once a halt opcode is seen
    always_comb begin
        halted_d = halted_q;
        if (opcode == OP_HALT) begin
            halted_d = 1'b1;
        end
    end

    // Halt flag register, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed plan steps plus random traffic vs a reference model.
module tb_cpu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [31:0] InputDataA, InputDataB, ImmediateDataB, MemDataOut;
    logic        ExtSel, PCWre, InsMemRW, RegOut, RegWre, ALUSrcB, ALUM2Reg, PCSrc, DataMemRW;
    logic [2:0]  ALUOp;
    logic [31:0] result, WriteData;
    logic        zero, halted;

    // Stand-alone ALU instance to reach function codes the decoder never emits
    logic [31:0] ta, tb_r, timm, t_res;
    logic        tsrc, t_zero;
    logic [2:0]  top_op;

    int total = 0;
    int bad   = 0;
    bit m_halted;

    always #5 clk = ~clk;

    cpu_exec_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .InputDataA(InputDataA), .InputDataB(InputDataB),
        .ImmediateDataB(ImmediateDataB), .MemDataOut(MemDataOut),
        .ExtSel(ExtSel), .PCWre(PCWre), .InsMemRW(InsMemRW), .RegOut(RegOut),
        .RegWre(RegWre), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
        .PCSrc(PCSrc), .DataMemRW(DataMemRW), .result(result), .zero(zero),
        .WriteData(WriteData), .halted(halted)
    );

    cpu_alu #(.WIDTH(32)) dut_alu (
        .a(ta), .b_reg(tb_r), .b_imm(timm), .alu_src_b(tsrc),
        .alu_op(top_op), .result(t_res), .zero(t_zero)
    );

    typedef struct {
        bit       ext, pcwre, regout, regwre, srcb, m2r, beq, dmw;
        bit [2:0] aluop;
    } ctl_t;

    // Spec decode table
    function automatic ctl_t ref_ctl(input logic [5:0] op);
        ctl_t c = '{ext:0, pcwre:1, regout:0, regwre:0, srcb:0, m2r:0, beq:0, dmw:0, aluop:3'd0};
        case (op)
            6'b000000: begin c.regout = 1; c.regwre = 1; c.ext = 1; end
            6'b000001: begin c.regwre = 1; c.srcb = 1; c.ext = 1; end
            6'b000010: begin c.regout = 1; c.regwre = 1; c.aluop = 3'd1; c.ext = 1; end
            6'b010000: begin c.regwre = 1; c.srcb = 1; c.aluop = 3'd3; end
            6'b010001: begin c.regout = 1; c.regwre = 1; c.aluop = 3'd4; end
            6'b010010: begin c.regout = 1; c.regwre = 1; c.aluop = 3'd3; end
            6'b100000: begin c.regout = 1; c.regwre = 1; end
            6'b100110: begin c.srcb = 1; c.ext = 1; c.dmw = 1; end
            6'b100111: begin c.srcb = 1; c.ext = 1; c.m2r = 1; c.regwre = 1; end
            6'b110000: begin c.aluop = 3'd1; c.ext = 1; c.beq = 1; end
            6'b111111: begin c.pcwre = 0; end
            default: ;
        endcase
        return c;
    endfunction

    // Spec ALU function table
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return b - a;
            3'd3: return a | b;
            3'd4: return a & b;
            3'd5: return ~a & b;
            3'd6: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one instruction, check every output against the model, then account for the coming edge
    task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] mem, input logic rst);
        ctl_t        c;
        logic [31:0] e_res;
        bit          blk;
        @(negedge clk);
        opcode = op; InputDataA = a; InputDataB = b; ImmediateDataB = imm;
        MemDataOut = mem; reset = rst;
        #1;
        c     = ref_ctl(op);
        e_res = ref_alu(c.aluop, a, c.srcb ? imm : b);
        blk   = m_halted || (op == 6'b111111);
        chk1 ("ExtSel",    ExtSel,    c.ext);
        chk1 ("InsMemRW",  InsMemRW,  1'b0);
        chk1 ("RegOut",    RegOut,    c.regout);
        chk32("ALUOp",     32'(ALUOp), 32'(c.aluop));
        chk1 ("ALUSrcB",   ALUSrcB,   c.srcb);
        chk1 ("ALUM2Reg",  ALUM2Reg,  c.m2r);
        chk32("result",    result,    e_res);
        chk1 ("zero",      zero,      e_res == 32'd0);
        chk32("WriteData", WriteData, c.m2r ? mem : e_res);
        chk1 ("PCWre",     PCWre,     !rst || (c.pcwre && !blk));
        chk1 ("RegWre",    RegWre,    rst && c.regwre && !blk);
        chk1 ("DataMemRW", DataMemRW, rst && c.dmw && !blk);
        chk1 ("PCSrc",     PCSrc,     rst && c.beq && (e_res == 32'd0) && !blk);
        chk1 ("halted",    halted,    m_halted);
        if (!rst)                m_halted = 1'b0;
        else if (op == 6'b111111) m_halted = 1'b1;
    endtask

    logic [5:0]  ops [11];
    logic [31:0] sweep_exp [8];

    initial begin
        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                6'b100000, 6'b100110, 6'b100111, 6'b110000, 6'b111111};
        sweep_exp = '{32'h00E100E0, 32'hE100E100, 32'h1EFF1F00, 32'hFFF0FFF0,
                      32'h00F000F0, 32'h0F000F00, 32'hFF00FF00, 32'h00FF00FF};
        reset = 1'b0; opcode = '0;
        InputDataA = '0; InputDataB = '0; ImmediateDataB = '0; MemDataOut = '0;
        ta = '0; tb_r = '0; timm = '0; tsrc = 1'b0; top_op = '0;
        repeat (2) @(posedge clk);
        m_halted = 1'b0;

        // Reset state, including a halt opcode while reset is held
        apply(6'b111111, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_pcwre",  PCWre,  1'b1);
        apply(6'b000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        chk1("rst_halt_same_edge", halted, 1'b0);

        // add
        apply(6'b000000, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1);
        chk32("add_result", result, 32'd12);
        chk1 ("add_regwre", RegWre, 1'b1);
        chk32("add_wd",     WriteData, 32'd12);

        // ori zero-extended immediate
        apply(6'b010000, 32'h00F0, 32'h1234, 32'h000F, 32'd0, 1'b1);
        chk32("ori_result", result, 32'h00FF);
        chk1 ("ori_extsel", ExtSel, 1'b0);

        // beq taken / not taken / wrap
        apply(6'b110000, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1);
        chk1("beq_taken", PCSrc, 1'b1);
        apply(6'b110000, 32'd9, 32'd8, 32'd0, 32'd0, 1'b1);
        chk1("beq_not", PCSrc, 1'b0);
        apply(6'b110000, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1);
        chk32("sub_wrap", result, 32'hFFFFFFFF);

        // lw / sw
        apply(6'b100111, 32'h10, 32'd0, 32'd4, 32'hDEADBEEF, 1'b1);
        chk32("lw_wd", WriteData, 32'hDEADBEEF);
        apply(6'b100110, 32'h10, 32'd0, 32'd4, 32'hDEADBEEF, 1'b1);
        chk32("sw_addr", result, 32'h14);
        chk1 ("sw_dmw",  DataMemRW, 1'b1);

        // halt, sticky blocking, then reset clears
        apply(6'b111111, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1);
        apply(6'b000000, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1);
        chk1("halt_set",    halted, 1'b1);
        chk1("halt_pcwre",  PCWre,  1'b0);
        chk1("halt_regwre", RegWre, 1'b0);
        chk32("halt_alu_live", result, 32'd3);
        apply(6'b110000, 32'd4, 32'd4, 32'd0, 32'd0, 1'b1);
        chk1("halt_pcsrc", PCSrc, 1'b0);
        apply(6'b000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        apply(6'b000000, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1);
        chk1("unhalt",       halted, 1'b0);
        chk1("unhalt_pcwre", PCWre,  1'b1);

        // Illegal opcode behaves as NOP
        apply(6'b000111, 32'd6, 32'd6, 32'd0, 32'd0, 1'b1);
        chk1("nop_regwre", RegWre,    1'b0);
        chk1("nop_dmw",    DataMemRW, 1'b0);
        chk1("nop_pcwre",  PCWre,     1'b1);

        // Direct ALU sweep of all eight functions
        ta = 32'hF0F0F0F0; tb_r = 32'h0FF00FF0; timm = 32'h12345678; tsrc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            top_op = 3'(i);
            #1;
            chk32($sformatf("alu_sweep%0d", i), t_res, sweep_exp[i]);
        end
        tsrc = 1'b1; top_op = 3'd6; #1;
        chk32("alu_srcb_imm", t_res, 32'hF0F0F0F0 ^ 32'h12345678);
        ta = 32'h5A5A5A5A; tsrc = 1'b0; tb_r = 32'h5A5A5A5A; top_op = 3'd6; #1;
        chk1("alu_zero", t_zero, 1'b1);
        for (int i = 0; i < 64; i++) begin
            ta = $urandom; tb_r = $urandom; timm = $urandom;
            tsrc = 1'($urandom_range(0, 1)); top_op = 3'($urandom_range(0, 7));
            #1;
            chk32("alu_rand", t_res, ref_alu(top_op, ta, tsrc ? timm : tb_r));
        end

        // Randomized instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  op;
            logic [31:0] a, b;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            apply(op, a, b, $urandom, $urandom, $urandom_range(0, 9) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
